// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 64-point streaming FFT twiddle stage.
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int TW_ADDR_W = 4;
  localparam int CNT_W     = $clog2(FFT_N);

  // Rotation of the first-quadrant ROM word by (-j)^k, k taken from e[5:4].
  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_e;

  function automatic logic [1:0] br2(input logic [1:0] q);
    return {q[0], q[1]};
  endfunction

endpackage

// File: rtl/cmul_round.sv
// Complex multiply with Q1.(WIDTH-1) round-half-up: products registered, then
// sum/round/limit into the outputs. FFT_TW_SATURATE_EN clamps; otherwise wraps.
module cmul_round #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int RW = WIDTH + 2;
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (WIDTH - 2));

  logic signed [PW-1:0] p_ac, p_bd, p_ad, p_bc;
  logic                 s3_valid, s3_last;
  logic signed [SW-1:0] sum_re, sum_im;
  logic signed [RW-1:0] rnd_re, rnd_im;
  logic [WIDTH-1:0]     lim_re, lim_im;
  logic                 unused_bits;

  always_ff @(posedge clock) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
    end else begin
      s3_valid <= in_valid;
      s3_last  <= in_last;
    end
  end

  always_ff @(posedge clock) begin
    p_ac <= $signed(a) * $signed(c);
    p_bd <= $signed(b) * $signed(d);
    p_ad <= $signed(a) * $signed(d);
    p_bc <= $signed(b) * $signed(c);
  end

`ifdef FFT_TW_SATURATE_EN
  function automatic logic [WIDTH-1:0] limit(input logic signed [RW-1:0] v);
    if (v > RW'(2 ** (WIDTH - 1) - 1)) return {1'b0, {(WIDTH-1){1'b1}}};
    if (v < RW'(-(2 ** (WIDTH - 1))))  return {1'b1, {(WIDTH-1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

  assign unused_bits = ^{sum_re[WIDTH-2:0], sum_im[WIDTH-2:0]};
`else
  assign unused_bits = ^{sum_re[WIDTH-2:0], sum_im[WIDTH-2:0],
                         rnd_re[RW-1:WIDTH], rnd_im[RW-1:WIDTH]};
`endif

  // Dropping the low WIDTH-1 bits of the rounded sum is the arithmetic shift.
  always_comb begin
    sum_re = {p_ac[PW-1], p_ac} - {p_bd[PW-1], p_bd} + HALF;
    sum_im = {p_ad[PW-1], p_ad} + {p_bc[PW-1], p_bc} + HALF;
    rnd_re = sum_re[SW-1:WIDTH-1];
    rnd_im = sum_im[SW-1:WIDTH-1];
`ifdef FFT_TW_SATURATE_EN
    lim_re = limit(rnd_re);
    lim_im = limit(rnd_im);
`else
    lim_re = rnd_re[WIDTH-1:0];
    lim_im = rnd_im[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= s3_valid;
      out_last  <= s3_valid & s3_last;
      if (s3_valid) begin
        out_re <= lim_re;
        out_im <= lim_im;
      end
    end
  end

endmodule

// File: rtl/twiddle_mult.sv
// Twiddle-multiply stage of the 64-point FFT: counter, ROM addressing, quadrant
// rotation and rounded complex product. FFT_TW_SATURATE_EN selects clamping.
module twiddle_mult
  import fft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_re,
  input  logic [WIDTH-1:0]     in_im,
  output logic [TW_ADDR_W-1:0] tw_addr,
  input  logic [WIDTH-1:0]     tw_re,
  input  logic [WIDTH-1:0]     tw_im,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_re,
  output logic [WIDTH-1:0]     out_im,
  output logic                 out_last
);
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] e;

  logic             s1_valid, s1_last;
  rot_e             s1_rot;
  logic [WIDTH-1:0] s1_re, s1_im;

  logic [WIDTH-1:0] rot_c, rot_d;
  logic             s2_valid, s2_last;
  logic [WIDTH-1:0] s2_a, s2_b, s2_c, s2_d;

  // e = r * br2(q) never exceeds 45, so the 6-bit product needs no modulo.
  always_comb begin
    e       = CNT_W'(n[TW_ADDR_W-1:0]) * CNT_W'(br2(n[CNT_W-1:TW_ADDR_W]));
    tw_addr = e[TW_ADDR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n <= '0;
    end else if (in_valid) begin
      n <= n + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid && (n == CNT_W'(FFT_N - 1));
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  always_ff @(posedge clock) begin
    s1_re  <= in_re;
    s1_im  <= in_im;
    s1_rot <= rot_e'(e[CNT_W-1:TW_ADDR_W]);
    s2_a   <= s1_re;
    s2_b   <= s1_im;
    s2_c   <= rot_c;
    s2_d   <= rot_d;
  end

  // ROM word arrives in S1, aligned with the data registered there.
  always_comb begin
    rot_c = tw_re;
    rot_d = tw_im;
    case (s1_rot)
      ROT_90:  begin rot_c = tw_im;  rot_d = -tw_re; end
      ROT_180: begin rot_c = -tw_re; rot_d = -tw_im; end
      ROT_270: begin rot_c = -tw_im; rot_d = tw_re;  end
      default: begin rot_c = tw_re;  rot_d = tw_im;  end
    endcase
  end

  cmul_round #(
    .WIDTH(WIDTH)
  ) u_cmul (
    .clock    (clock),
    .reset    (reset),
    .in_valid (s2_valid),
    .in_last  (s2_last),
    .a        (s2_a),
    .b        (s2_b),
    .c        (s2_c),
    .d        (s2_d),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_re   (out_re),
    .out_im   (out_im)
  );

endmodule

// File: tb/tb_twiddle_mult.sv
// Directed-vector and scoreboard bench for twiddle_mult, with a registered ROM model.
module tb_twiddle_mult;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_re, in_im;
  logic [3:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        out_valid;
  logic [15:0] out_re, out_im;
  logic        out_last;

  typedef struct {
    int          n;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic [3:0]  exp_addr;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
  } vec_t;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        last;
    int          cyc;
  } exp_t;

  int rom_c [16] = '{32767, 32609, 32137, 31356, 30273, 28898, 27245, 25329,
                     23170, 20787, 18204, 15446, 12539, 9512, 6393, 3212};
  int rom_s [16] = '{0, 3212, 6393, 9512, 12539, 15446, 18204, 20787,
                     23170, 25329, 27245, 28898, 30273, 31356, 32137, 32609};

  vec_t vec [7];
  exp_t exp_q [$];
  int   checks  = 0;
  int   passes  = 0;
  int   bench_n = 0;
  int   cyc     = 0;

  twiddle_mult #(.WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .tw_addr  (tw_addr),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .out_valid(out_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    tw_re <= 16'(rom_c[tw_addr]);
    tw_im <= 16'(-rom_s[tw_addr]);
  end

  function automatic int tw_exp(input int n);
    int q, r, br;
    q  = n / 16;
    r  = n % 16;
    br = (q == 1) ? 2 : (q == 2) ? 1 : q;
    return r * br;
  endfunction

  function automatic exp_t ref_out(input logic [15:0] a_i, input logic [15:0] b_i, input int n);
    exp_t   it;
    int     e, k, addr;
    longint a, b, c, d, tc, td, re, im;
    e    = tw_exp(n);
    addr = e % 16;
    k    = e / 16;
    c    = rom_c[addr];
    d    = -rom_s[addr];
    case (k)
      0:       begin tc = c;  td = d;  end
      1:       begin tc = d;  td = -c; end
      2:       begin tc = -c; td = -d; end
      default: begin tc = -d; td = c;  end
    endcase
    a  = longint'($signed(a_i));
    b  = longint'($signed(b_i));
    re = (a * tc - b * td + 16384) >>> 15;
    im = (a * td + b * tc + 16384) >>> 15;
`ifdef FFT_TW_SATURATE_EN
    if (re > 32767)  re = 32767;
    if (re < -32768) re = -32768;
    if (im > 32767)  im = 32767;
    if (im < -32768) im = -32768;
`endif
    it.re   = re[15:0];
    it.im   = im[15:0];
    it.last = (n == 63);
    it.cyc  = cyc;
    return it;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Called at a falling edge; holds the inputs for one full cycle.
  task automatic applyStimulus(input logic v, input logic [15:0] re, input logic [15:0] im);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    if (v) begin
      checkOutput($sformatf("tw_addr n=%0d", bench_n), 32'(tw_addr), 32'(tw_exp(bench_n) % 16));
      exp_q.push_back(ref_out(re, im, bench_n));
      bench_n = (bench_n + 1) % 64;
    end
    @(negedge clock);
  endtask

  task automatic doReset(input int ncyc, input logic busy);
    reset    = 1'b1;
    in_valid = busy;
    in_re    = 16'($urandom);
    in_im    = 16'($urandom);
    @(posedge clock);
    #1;
    exp_q.delete();
    bench_n = 0;
    repeat (ncyc) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected out_valid: got re=0x%0h im=0x%0h, required no output", out_re, out_im);
      end else begin
        exp_t it;
        it = exp_q.pop_front();
        checkOutput("stream data", {out_re, out_im}, {it.re, it.im});
        checkOutput("stream out_last", 32'(out_last), 32'(it.last));
        checkOutput("stream latency", 32'(cyc - it.cyc), 32'd4);
      end
    end
  end

  initial begin
    vec[0] = '{0,  16'h4000, 16'h0000, 4'd0,  16'h4000, 16'h0000};
    vec[1] = '{8,  16'h2000, 16'h1000, 4'd0,  16'h2000, 16'h1000};
    vec[2] = '{17, 16'h4000, 16'h0000, 4'd2,  16'h3EC5, 16'hF384};
    vec[3] = '{24, 16'h4000, 16'h0000, 4'd0,  16'h0000, 16'hC001};
`ifdef FFT_TW_SATURATE_EN
    vec[4] = '{40, 16'h8000, 16'h8000, 4'd8,  16'h8000, 16'h0000};
`else
    vec[4] = '{40, 16'h8000, 16'h8000, 4'd8,  16'h4AFC, 16'h0000};
`endif
    vec[5] = '{56, 16'h4000, 16'h0000, 4'd8,  16'hD2BF, 16'hD2BF};
    vec[6] = '{63, 16'h7FFF, 16'h0000, 4'd13, 16'hDAD8, 16'h7A7B};

    // in_valid held high throughout reset must not advance the counter.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_re    = 16'h1234;
    in_im    = 16'h5678;
    repeat (3) @(negedge clock);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    checkOutput("reset out_re", 32'(out_re), 32'd0);
    checkOutput("reset out_im", 32'(out_im), 32'd0);
    checkOutput("reset tw_addr", 32'(tw_addr), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      while (bench_n != vec[i].n) applyStimulus(1'b1, 16'h0000, 16'h0000);
      checkOutput($sformatf("vec%0d tw_addr", i), 32'(tw_addr), 32'(vec[i].exp_addr));
      applyStimulus(1'b1, vec[i].in_re, vec[i].in_im);
      repeat (3) applyStimulus(1'b0, 16'h0000, 16'h0000);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_re", i), 32'(out_re), 32'(vec[i].exp_re));
      checkOutput($sformatf("vec%0d out_im", i), 32'(out_im), 32'(vec[i].exp_im));
      checkOutput($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vec[i].n == 63));
      applyStimulus(1'b0, 16'h0000, 16'h0000);
      checkOutput($sformatf("vec%0d valid single", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("vec%0d hold re", i), 32'(out_re), 32'(vec[i].exp_re));
      checkOutput($sformatf("vec%0d hold im", i), 32'(out_im), 32'(vec[i].exp_im));
    end

    $display("[TB] full frame with alternating in_valid");
    checkOutput("frame start tw_addr", 32'(tw_addr), 32'd0);
    for (int i = 0; i < 128; i++) applyStimulus(i % 2 == 0, 16'($urandom), 16'($urandom));
    checkOutput("wrap tw_addr", 32'(tw_addr), 32'd0);
    applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    repeat (6) applyStimulus(1'b0, 16'h0000, 16'h0000);

    $display("[TB] reset mid-frame");
    while (bench_n != 30) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    doReset(2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("no valid after reset %0d", i), 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 16'h0000, 16'h0000);
    end
    checkOutput("first after reset tw_addr", 32'(tw_addr), 32'd0);
    applyStimulus(1'b1, 16'h4000, 16'h0000);
    repeat (6) applyStimulus(1'b0, 16'h0000, 16'h0000);

    $display("[TB] back-to-back 128 samples");
    doReset(1, 1'b0);
    for (int i = 0; i < 128; i++) applyStimulus(1'b1, 16'($urandom), 16'($urandom));
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    checkOutput("drain queue empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
